serial_add_sub: RTL

//   Parametrised multi-cycle adder/subtractor. Successor to the single-bit gate-level half adder.

---
 rtl/serial_add_sub.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub
//   Multi-cycle adder/subtractor. Processes WIDTH-bit operands DIGIT bits per clock, LSB
//   first, through a single DIGIT-bit ripple slice and a registered carry. Subtraction is
//   done as A + ~B + 1. Reports carry-out and signed overflow.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits per clock; must divide WIDTH exactly
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   request; accepted only when idle or in the done cycle
//   a, b   in   operands, captured on the accepting edge
//   cin    in   carry-in for add; ignored when sub=1
//   sub    in   0: a+b+cin, 1: a-b
//   busy   out  high while the operation is running
//   done   out  one-cycle pulse, result valid
//   sum    out  result, held until the next result
//   cout   out  carry out of the MSB (for sub, 1 = no borrow)
//   ovf    out  signed overflow

module serial_add_sub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTEP  = WIDTH / DIGIT;
    // One extra bit so the counter is never zero-width, even when NSTEP == 1.
    localparam int unsigned STEP_W = $clog2(NSTEP) + 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT-1:0]   slice_sum;
    logic               slice_cout;
    logic               slice_cmsb;
    logic               accept;

    // Ripple slice over the low DIGIT bits of the operand shift registers. slice_cmsb is the
    // carry into the top bit of the slice; on the last step that is the carry into the MSB.
    always_comb begin
        logic c;
        c          = carry_q;
        slice_cmsb = carry_q;
        slice_sum  = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            slice_cmsb   = c;
            slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
            c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        slice_cout = c;
    end

    // A new request is taken in IDLE and also in the DONE cycle (back-to-back).
    assign accept = start && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        step_d  = step_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_cout;
                // New digit enters at the top; after NSTEP shifts the LSB digit is at bit 0.
                acc_d   = (acc_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
                step_d  = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d = StDone;
                    sum_d   = acc_d;
                    cout_d  = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            state_d = StRun;
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            acc_d   = '0;
            step_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            step_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
